// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and core
// control/status signals of the instruction memory loader.
interface imem_loader_if #(
    parameter int unsigned NUM_INST  = 128,
    parameter int unsigned REG_WIDTH = 32
) ();
    logic                         start;
    logic                         in_valid;
    logic [7:0]                   in_data;
    logic                         in_ready;
    logic                         imem_we;
    logic [$clog2(NUM_INST)-1:0]  imem_addr;
    logic [REG_WIDTH-1:0]         imem_wdata;
    logic                         core_rstn;
    logic                         done;
    logic                         error;

    // Host / stream source side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed little-endian byte stream, writes
// the words into instruction memory and then releases the core from reset.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader #(
    parameter int unsigned NUM_INST  = 128,
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    imem_loader_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_INST);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN0 = 3'd1;
    localparam logic [2:0] LEN1 = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHK  = 3'd4;
`endif
    localparam logic [2:0] RUN  = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [23:0]          asm_q, asm_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic                 in_ready_q, in_ready_d;
    logic                 core_rstn_q, core_rstn_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif
    logic                 accept_c;
    logic [15:0]          len_full_c;

    assign accept_c   = bus.in_valid & in_ready_q;
    assign len_full_c = {bus.in_data, len_q[7:0]};

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        case (state_q)
            IDLE, RUN, ERR: begin
                if (bus.start) begin
                    state_d = LEN0;
                    len_d   = 16'd0;
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end
            end
            LEN0: begin
                if (accept_c) begin
                    len_d[7:0] = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ bus.in_data;
`endif
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept_c) begin
                    len_d = len_full_c;
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.in_data;
`endif
                    if (len_full_c == 16'd0 || len_full_c > 16'(NUM_INST)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ bus.in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = REG_WIDTH'({bus.in_data, asm_q});
                        bcnt_d  = 2'd0;
                        // Index holds on the last word so it never passes N-1
                        if (16'(idx_q) == len_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = RUN;
`endif
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else begin
                        asm_d[bcnt_q*8 +: 8] = bus.in_data;
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept_c) begin
                    state_d = (bus.in_data == xor_q) ? RUN : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_d == CHK)
`endif
                      ;
        core_rstn_d = (state_d == RUN);
        done_d      = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    // State and output registers; reset aborts any load at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= 16'd0;
            idx_q       <= '0;
            bcnt_q      <= 2'd0;
            asm_q       <= 24'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            in_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            in_ready_q  <= in_ready_d;
            core_rstn_q <= core_rstn_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rstn  = core_rstn_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads against a stream-level reference model;
// expected memory writes go into a scoreboard queue checked by a monitor.
module tb_imem_loader;
    localparam int unsigned NUM_INST  = 128;
    localparam int unsigned REG_WIDTH = 32;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rstn;
    imem_loader_if #(.NUM_INST(NUM_INST), .REG_WIDTH(REG_WIDTH)) bus ();

    imem_loader #(.NUM_INST(NUM_INST), .REG_WIDTH(REG_WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    wr_t exp_q[$];
    logic [31:0] words[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b, required 1 within 50 cycles", bus.in_ready);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_done_low",     32'(bus.done),      32'd0);
        chk("start_error_low",    32'(bus.error),     32'd0);
        chk("start_core_rstn_lo", 32'(bus.core_rstn), 32'd0);
        chk("start_in_ready",     32'(bus.in_ready),  32'd1);
    endtask

    // One complete load of n words taken from 'words'; mode 1 = random
    // stalls, mode 2 = five idle cycles inside word 1
    task automatic run_load(input int n, input int mode, input bit bad_chk);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] nn;
        logic [31:0] w;
        wr_t         e;
        bit          ok;
        bit          exp_run;
        nn = 16'(n);
        ok = (n >= 1) && (n <= int'(NUM_INST));
        pulse_start();
        bytes.push_back(nn[7:0]);
        bytes.push_back(nn[15:8]);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                e.addr = 7'(i);
                e.data = w;
                exp_q.push_back(e);
                for (int k = 0; k < 4; k++) bytes.push_back(w[k*8 +: 8]);
            end
            if (CHK_EN) begin
                x = 8'd0;
                foreach (bytes[i]) x = x ^ bytes[i];
                bytes.push_back(bad_chk ? ~x : x);
            end
        end
        for (int i = 0; i < bytes.size(); i++) begin
            if (mode == 1 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            if (mode == 2 && i == 8) idle(5);
            send_byte(bytes[i]);
        end
        idle(3);
        exp_run = ok && !(CHK_EN && bad_chk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        chk("end_done",      32'(bus.done),      32'(exp_run));
        chk("end_core_rstn", 32'(bus.core_rstn), 32'(exp_run));
        chk("end_error",     32'(bus.error),     32'(!exp_run));
        chk("end_in_ready",  32'(bus.in_ready),  32'd0);
        exp_q.delete();
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
        chk({tag, "_core_rstn"},  32'(bus.core_rstn),  32'd0);
        chk({tag, "_done"},       32'(bus.done),       32'd0);
        chk({tag, "_error"},      32'(bus.error),      32'd0);
    endtask

    initial begin
        wr_t e;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Watchdog
        fork
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached, required completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Write monitor: every strobe must match the head of the scoreboard
        fork
            forever begin
                @(negedge clk);
                if (bus.imem_we === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                                 bus.imem_addr, bus.imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
                        chk("write_data", bus.imem_wdata, e.data);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        chk("idle_no_start_ready", 32'(bus.in_ready), 32'd0);

        // Single NOP word
        words.delete();
        words.push_back(32'h0000_0013);
        run_load(1, 0, 1'b0);

        // Three words with a stall inside word 1 (also start from RUN)
        rand_words(3);
        run_load(3, 2, 1'b0);

        // Length out of range, then zero length
        words.delete();
        run_load(129, 0, 1'b0);
        run_load(0, 0, 1'b0);

        // Full-depth load from ERR
        rand_words(int'(NUM_INST));
        run_load(int'(NUM_INST), 1, 1'b0);

        // Checksum corruption (only an error when the checksum is built)
        rand_words(2);
        run_load(2, 0, 1'b1);

        // Reset after 2nd byte of word 0
        pulse_start();
        send_byte(8'd2);
        send_byte(8'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_all_zero("midload_reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(4);
        chk("post_reset_idle_ready", 32'(bus.in_ready),  32'd0);
        chk("post_reset_core_rstn",  32'(bus.core_rstn), 32'd0);
        rand_words(2);
        run_load(2, 1, 1'b0);

        // Random loads
        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(1, 20));
            rand_words(n);
            run_load(n, 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL take parameter NUM_INST, default 128, as the instruction memory depth in words.
REQ-002 The block SHALL take parameter REG_WIDTH, default 32, as the instruction word width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  byte accepted when in_valid and in_ready are both high on a clk edge.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  $clog2(NUM_INST)  word index.
- imem_wdata  output  REG_WIDTH  instruction word.
- core_rstn  output  1  active-low reset to the processor core.
- done  output  1  load complete and core running.
- error  output  1  load aborted.

Function
REQ-005 The FSM SHALL have the states IDLE, LEN0, LEN1, DATA, CHK, RUN and ERR.
REQ-006 The stream format SHALL be: word count N as 2 bytes little-endian, then N words of 4 bytes each, little-endian.
REQ-007 A start pulse in IDLE, RUN or ERR SHALL move the FSM to LEN0 on the next edge. The same edge SHALL clear done, error and the word index, and drive core_rstn low.
REQ-008 start SHALL be ignored in LEN0, LEN1, DATA and CHK.
REQ-009 in_ready SHALL be high only in LEN0, LEN1, DATA and CHK, and SHALL have no combinational dependence on in_valid.
REQ-010 Transitions on accepted bytes:
- LEN0 -> LEN1 on one accepted byte.
- LEN1 -> DATA on the next accepted byte.
- If N == 0 or N > NUM_INST, LEN1 SHALL go to ERR instead of DATA.
REQ-011 In DATA, the accepted bytes SHALL be assembled into a word, least significant byte first.
REQ-012 On the edge that accepts the 4th byte of a word, imem_we, imem_addr (the current word index) and imem_wdata SHALL be registered. imem_we SHALL then be high for exactly one cycle, and the word index SHALL increment by 1.
REQ-013 After word N-1 is written, the FSM SHALL go to CHK if LOADER_CHECKSUM_EN is defined, and to RUN otherwise.
REQ-014 In RUN, core_rstn SHALL be 1 and done SHALL be 1; both SHALL be registered outputs.
REQ-015 In ERR, error SHALL be 1 and core_rstn SHALL be 0; the FSM SHALL leave ERR only on start.
REQ-016 Cycles with in_valid low SHALL stall the FSM and the byte assembly without losing state. There SHALL be no timeout.
REQ-017 The word index SHALL never exceed N-1, and no write SHALL occur outside 0..N-1.

Reset
REQ-018 While rstn is low, the FSM SHALL be in IDLE and every output SHALL be 0 (including core_rstn = 0 and imem_we = 0). The word index, byte counter and checksum SHALL be 0.
REQ-019 A reset asserted mid-load SHALL abort the load immediately with no further imem_we pulse. After release, the FSM SHALL wait in IDLE for start.

Configuration
REQ-020 When LOADER_CHECKSUM_EN is defined:
- The block SHALL keep a running XOR of all length and data bytes.
- CHK SHALL accept one trailing byte.
- If that byte equals the running XOR, the FSM SHALL go to RUN; otherwise it SHALL go to ERR.
REQ-021 When LOADER_CHECKSUM_EN is undefined, the CHK state and the XOR register SHALL not be built. DATA SHALL go directly to RUN, and no trailing byte SHALL be consumed.

Verification
REQ-022 Scenario: start, stream 01 00 13 00 00 00 (addi x0,x0,0), in_valid always high -> one imem_we with addr 0 and wdata 0x00000013; core_rstn = 1 and done = 1 after the last byte (plus the checksum byte 0x12 when enabled).
REQ-023 Scenario: N = 3, with in_valid low for 5 cycles inside word 1 -> three writes to addr 0, 1, 2 with correct words; no extra or duplicated write.
REQ-024 Scenario: length bytes 81 00 (N = 129 > 128) -> ERR, error = 1, core_rstn = 0, no imem_we.
REQ-025 Scenario: rstn pulled low after the 2nd byte of word 0 -> all outputs 0 at once; after release and start, a full reload succeeds.
REQ-026 Scenario, LOADER_CHECKSUM_EN defined: a valid stream with a wrong checksum byte -> error = 1, core_rstn = 0. A correct checksum -> done = 1.
REQ-027 Scenario: start in RUN -> core_rstn goes 0 and done goes 0 the next cycle, and a new load proceeds.
